// File: rtl/scan_decoder.sv
// One-hot select driver: holds one line (direct) or walks start..last with wrap and per-line dwell (scan).
// Outputs registered; load shows onehot(address) right after its edge; enable=0 blanks the bus and pauses the scan.
module scan_decoder #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DWELL_WIDTH = 8,
  localparam int N = 1 << ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   load,
  input  logic                   stop,
  input  logic                   mode,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [ADDR_WIDTH-1:0]  scan_last,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [N-1:0]           out,
  output logic [ADDR_WIDTH-1:0]  cur_address,
  output logic                   busy,
  output logic                   wrap
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIRECT = 2'd1, SCAN = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cur_q, cur_d;
  logic [ADDR_WIDTH-1:0]  start_q, start_d;
  logic [ADDR_WIDTH-1:0]  last_q, last_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [N-1:0]           out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    start_d = start_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (load) begin
      start_d = address;
      last_d  = scan_last;
      dwell_d = dwell;
      cur_d   = address;
      cnt_d   = '0;
      state_d = mode ? SCAN : DIRECT;
    end else if (state_q == SCAN && enable) begin
      if (cnt_q == dwell_q) begin
        cnt_d = '0;
        // Address increment wraps naturally past the top line when last < start.
        if (cur_q == last_q) begin
          cur_d  = start_q;
          wrap_d = 1'b1;
        end else begin
          cur_d = cur_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
    out_d  = (busy_d && enable) ? ({{(N-1){1'b0}}, 1'b1} << cur_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      start_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      start_q <= start_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out         = out_q;
  assign cur_address = cur_q;
  assign busy        = busy_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed plus random bench for scan_decoder against a list-of-lines scan model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       reset, enable, load, stop, mode;
  logic [2:0] address, scan_last;
  logic [7:0] dwell;
  logic [7:0] out;
  logic [2:0] cur_address;
  logic       busy, wrap;

  scan_decoder #(.ADDR_WIDTH(3), .DWELL_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .stop(stop),
    .mode(mode), .address(address), .scan_last(scan_last), .dwell(dwell),
    .out(out), .cur_address(cur_address), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: scan is a precomputed list of lines, an index into it and a hold count.
  int         m_state;  // 0 idle, 1 direct, 2 scan
  logic [2:0] m_seq[$];
  int         m_idx, m_hold, m_dwell;
  logic [2:0] m_cur;
  logic [7:0] m_out;
  logic       m_busy, m_wrap;

  task model_step();
    logic [2:0] a;
    m_wrap = 1'b0;
    if (reset) begin
      m_state = 0; m_cur = 3'd0; m_seq.delete(); m_idx = 0; m_hold = 0; m_dwell = 0;
    end else if (stop) begin
      m_state = 0;
    end else if (load) begin
      m_state = mode ? 2 : 1;
      m_cur   = address;
      m_dwell = int'(dwell);
      m_hold  = 0;
      m_idx   = 0;
      m_seq.delete();
      a = address;
      for (int k = 0; k < 8; k++) begin
        m_seq.push_back(a);
        if (a == scan_last) break;
        a = 3'((int'(a) + 1) % 8);
      end
    end else if (m_state == 2 && enable) begin
      m_hold++;
      if (m_hold > m_dwell) begin
        m_hold = 0;
        m_idx  = (m_idx + 1) % m_seq.size();
        m_wrap = (m_idx == 0);
        m_cur  = m_seq[m_idx];
      end
    end
    m_busy = (m_state != 0);
    m_out  = (m_busy && enable) ? (8'd1 << m_cur) : 8'd0;
  endtask

  task check_all(input string tag);
    checks++;
    assert (out === m_out) else begin
      errors++; $error("FAIL %s out got %h expected %h", tag, out, m_out);
    end
    checks++;
    assert (cur_address === m_cur) else begin
      errors++; $error("FAIL %s cur_address got %0d expected %0d", tag, cur_address, m_cur);
    end
    checks++;
    assert (busy === m_busy) else begin
      errors++; $error("FAIL %s busy got %b expected %b", tag, busy, m_busy);
    end
    checks++;
    assert (wrap === m_wrap) else begin
      errors++; $error("FAIL %s wrap got %b expected %b", tag, wrap, m_wrap);
    end
  endtask

  task tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task wait_cur(input logic [2:0] target, input string tag);
    int n;
    n = 0;
    while (m_cur != target && n < 40) begin
      tick(tag);
      n++;
    end
    checks++;
    assert (m_cur == target) else begin
      errors++; $error("FAIL %s timeout waiting for line %0d, at %0d", tag, target, m_cur);
    end
  endtask

  task set_load(input logic md, input logic [2:0] a, input logic [2:0] l, input logic [7:0] d);
    load = 1'b1; mode = md; address = a; scan_last = l; dwell = d;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; load = 1'b0; stop = 1'b0; mode = 1'b0;
    address = 3'd0; scan_last = 3'd0; dwell = 8'd0;
    #2;
    tick("reset"); tick("reset");
    reset = 1'b0;
    repeat (2) tick("idle");

    // Direct mode; address changes afterward must not move the line.
    set_load(1'b0, 3'd5, 3'd0, 8'd0); tick("direct_load");
    load = 1'b0; address = 3'd1; tick("direct_hold");
    checks++;
    assert (out === 8'h20) else begin errors++; $error("FAIL direct_const out got %h expected 20", out); end
    enable = 1'b0; tick("direct_off");
    enable = 1'b1; tick("direct_on");

    // Scan 2..4 with dwell 1.
    set_load(1'b1, 3'd2, 3'd4, 8'd1); tick("scan_load");
    load = 1'b0; mode = 1'b0; dwell = 8'd7;
    repeat (12) tick("scan_dwell");

    // Wrap-around 6..1 with pause at line 0.
    set_load(1'b1, 3'd6, 3'd1, 8'd0); tick("wrap_load");
    load = 1'b0;
    wait_cur(3'd0, "wrap_to0");
    enable = 1'b0; repeat (3) tick("paused");
    checks++;
    assert (out === 8'h00 && cur_address === 3'd0) else begin
      errors++; $error("FAIL pause_const out %h cur %0d expected 00 and 0", out, cur_address);
    end
    enable = 1'b1; repeat (6) tick("resume");

    // Single-line scan: wrap every dwell+1 cycles.
    set_load(1'b1, 3'd4, 3'd4, 8'd2); tick("single_load");
    load = 1'b0; repeat (9) tick("single");

    // stop beats load.
    stop = 1'b1; set_load(1'b0, 3'd7, 3'd7, 8'd0); tick("stop_load");
    stop = 1'b0; load = 1'b0; tick("stopped");
    set_load(1'b0, 3'd3, 3'd0, 8'd0); tick("reload");
    load = 1'b0; tick("reload_hold");

    // Reset mid-scan beats load.
    set_load(1'b1, 3'd2, 3'd5, 8'd0); tick("pre_reset_load");
    load = 1'b0;
    wait_cur(3'd3, "to3");
    reset = 1'b1; set_load(1'b1, 3'd6, 3'd7, 8'd0); tick("reset_mid");
    reset = 1'b0; load = 1'b0; tick("after_reset");

    // Random traffic, dwell kept small so scans cycle often.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) < 2);
      stop      = ($urandom_range(0, 99) < 4);
      load      = ($urandom_range(0, 99) < 10);
      enable    = ($urandom_range(0, 99) < 85);
      mode      = 1'($urandom);
      address   = 3'($urandom);
      scan_last = 3'($urandom);
      dwell     = 8'($urandom_range(0, 3));
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
